// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types for the PLL lock supervisor.
// State encoding and the counter width helper.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   // Bits needed to hold a count up to v.
   function automatic int cnt_w(input int v);
      return $clog2(v) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous level.
// Both stages reset low.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // capture the async level through two back-to-back flops
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses PLL RST, qualifies LOCK, then
// releases channel resets in staggered order; drops all on loss.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int NUM_CH              = 3,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 250000,
   parameter int STAGGER_CYCLES      = 32,
   parameter int CNT_W               = 8
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              locked,
   input  logic              force_relock,
   output logic              pll_rst,
   output logic [NUM_CH-1:0] rst_out,
   output logic              ready,
   output logic [CNT_W-1:0]  lock_loss_cnt,
   output logic              timeout_flag
);

   localparam int PLS_W = cnt_w(RST_PULSE_CYCLES);
   localparam int TMR_W = cnt_w(LOCK_TIMEOUT_CYCLES);
   localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
   localparam int STG_W = cnt_w(STAGGER_CYCLES);
   localparam int REL_W = cnt_w(NUM_CH);

   localparam logic [PLS_W-1:0] PLS_LAST =
      PLS_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   // The WAIT_LOCK cycle that first sees lock_s is stable
   // cycle one, so STABLE itself needs two fewer counts.
   localparam logic [STB_W-1:0] STB_LAST =
      STB_W'((LOCK_STABLE_CYCLES > 1) ?
             (LOCK_STABLE_CYCLES - 2) : 0);
   localparam logic [STG_W-1:0] STG_LAST =
      STG_W'(STAGGER_CYCLES - 1);
   localparam logic [REL_W-1:0] REL_LAST =
      REL_W'(NUM_CH - 1);

   logic             lock_s;
   state_t           state, state_n;
   logic [PLS_W-1:0] pls, pls_n;
   logic [TMR_W-1:0] tmr, tmr_n;
   logic [STB_W-1:0] stb, stb_n;
   logic [STG_W-1:0] stg, stg_n;
   logic [REL_W-1:0] rel, rel_n;
   logic [CNT_W-1:0] cnt_n;
   logic             tflag_n;
   logic             rel_go;
   logic             pll_rst_n;
   logic             ready_n;
   logic [NUM_CH-1:0] rst_out_n;

   sync_2ff u_lock_sync (
      .clk (clkin),
      .rst (rst),
      .d   (locked),
      .q   (lock_s)
   );

   // state, counters and registered outputs
   always_ff @(posedge clkin) begin
      if (rst) begin
         state         <= RESET_PLL;
         pls           <= '0;
         tmr           <= '0;
         stb           <= '0;
         stg           <= '0;
         rel           <= '0;
         pll_rst       <= 1'b1;
         rst_out       <= '1;
         ready         <= 1'b0;
         lock_loss_cnt <= '0;
         timeout_flag  <= 1'b0;
      end else begin
         state         <= state_n;
         pls           <= pls_n;
         tmr           <= tmr_n;
         stb           <= stb_n;
         stg           <= stg_n;
         rel           <= rel_n;
         pll_rst       <= pll_rst_n;
         rst_out       <= rst_out_n;
         ready         <= ready_n;
         lock_loss_cnt <= cnt_n;
         timeout_flag  <= tflag_n;
      end
   end

   // next state, counter updates, loss count and timeout flag
   always_comb begin
      state_n = state;
      pls_n   = pls;
      tmr_n   = tmr;
      stb_n   = stb;
      stg_n   = stg;
      rel_n   = rel;
      cnt_n   = lock_loss_cnt;
      tflag_n = timeout_flag;
      rel_go  = 1'b0;
      unique case (state)
         RESET_PLL: begin
            if (force_relock) begin
               pls_n = '0;
            end else if (pls == PLS_LAST) begin
               state_n = WAIT_LOCK;
               tmr_n   = '0;
            end else begin
               pls_n = pls + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (force_relock) begin
               state_n = RESET_PLL;
               pls_n   = '0;
            end else if (lock_s) begin
               if (LOCK_STABLE_CYCLES == 1) begin
                  rel_go = 1'b1;
               end else begin
                  state_n = STABLE;
                  stb_n   = '0;
               end
            end else if (tmr == TMR_LAST) begin
               tflag_n = 1'b1;
               state_n = RESET_PLL;
               pls_n   = '0;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         STABLE: begin
            if (force_relock) begin
               state_n = RESET_PLL;
               pls_n   = '0;
            end else if (!lock_s) begin
               state_n = WAIT_LOCK;
               tmr_n   = '0;
            end else if (stb == STB_LAST) begin
               rel_go = 1'b1;
            end else begin
               stb_n = stb + 1'b1;
            end
         end
         RELEASE, RUN: begin
            if (!lock_s || force_relock) begin
               state_n = RESET_PLL;
               pls_n   = '0;
               if (!lock_s && lock_loss_cnt != '1)
                  cnt_n = lock_loss_cnt + 1'b1;
            end else if (state == RELEASE) begin
               if (stg == STG_LAST) begin
                  stg_n = '0;
                  rel_n = rel + 1'b1;
                  if (rel == REL_LAST)
                     state_n = RUN;
               end else begin
                  stg_n = stg + 1'b1;
               end
            end
         end
         default: begin
            state_n = RESET_PLL;
            pls_n   = '0;
         end
      endcase
      // channel 0 leaves reset on the same edge as entry
      if (rel_go) begin
         stg_n   = '0;
         rel_n   = REL_W'(1);
         state_n = (NUM_CH == 1) ? RUN : RELEASE;
      end
   end

   // output values for the next edge, from the next state
   always_comb begin
      pll_rst_n = (state_n == RESET_PLL);
      ready_n   = (state_n == RUN);
      rst_out_n = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (state_n == RUN)
            rst_out_n[i] = 1'b0;
         else if (state_n == RELEASE)
            rst_out_n[i] = (REL_W'(i) >= rel_n);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario tasks with an event scoreboard
// on rst_out transitions, plus inline timing checks.
module tb_pll_lock_supervisor;

   typedef struct {
      int         cyc;
      logic [2:0] rst;
      logic       rdy;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       locked;
   logic       force_relock;
   logic       pll_rst;
   logic [2:0] rst_out;
   logic       ready;
   logic [1:0] lock_loss_cnt;
   logic       timeout_flag;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  exq[$];
   ev_t  obq[$];
   ev_t  mon_ev;
   logic [2:0] prev_rst = 3'b111;

   pll_lock_supervisor #(
      .NUM_CH              (3),
      .RST_PULSE_CYCLES    (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (50),
      .STAGGER_CYCLES      (3),
      .CNT_W               (2)
   ) dut (
      .clkin         (clk),
      .rst           (rst),
      .locked        (locked),
      .force_relock  (force_relock),
      .pll_rst       (pll_rst),
      .rst_out       (rst_out),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_flag  (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // record every rst_out change with its edge index
   always @(negedge clk) begin
      if (rst_out !== prev_rst) begin
         mon_ev.cyc = cyc;
         mon_ev.rst = rst_out;
         mon_ev.rdy = ready;
         obq.push_back(mon_ev);
      end
      prev_rst = rst_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int c, input logic [2:0] r,
                          input logic d);
      ev_t e;
      e.cyc = c;
      e.rst = r;
      e.rdy = d;
      exq.push_back(e);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      locked = 1'b0;
      force_relock = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      exq.delete();
      obq.delete();
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      locked = 1'b0;
      force_relock = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (pll_rst !== 1'b1) begin
         failures++;
         $display("FAIL reset_pll_rst got=%b exp=1", pll_rst);
      end
      checks++;
      if (rst_out !== 3'b111) begin
         failures++;
         $display("FAIL reset_rst_out got=%b exp=111", rst_out);
      end
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0", ready);
      end
      checks++;
      if (lock_loss_cnt !== 2'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d exp=0", lock_loss_cnt);
      end
      checks++;
      if (timeout_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_tflag got=%b exp=0", timeout_flag);
      end
      tick();
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (pll_rst === 1'b1) n++;
         else break;
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL first_pulse_len got=%0d exp=4", n);
      end
   endtask

   task automatic test_clean_lock();
      int a;
      ev_t e, o;
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      a = cyc;
      push_ev(a + 10, 3'b110, 1'b0);
      push_ev(a + 13, 3'b100, 1'b0);
      push_ev(a + 16, 3'b000, 1'b1);
      repeat (25) tick();
      while (exq.size() > 0) begin
         e = exq.pop_front();
         checks++;
         if (obq.size() == 0) begin
            failures++;
            $display("FAIL clean_seq missing cyc=%0d exp=%b",
                     e.cyc, e.rst);
         end else begin
            o = obq.pop_front();
            if (o.cyc !== e.cyc || o.rst !== e.rst ||
                o.rdy !== e.rdy) begin
               failures++;
               $display("FAIL clean_seq got=%0d/%b/%b exp=%0d/%b/%b",
                        o.cyc, o.rst, o.rdy, e.cyc, e.rst, e.rdy);
            end
         end
      end
      checks++;
      if (obq.size() != 0) begin
         failures++;
         $display("FAIL clean_extra got=%0d exp=0", obq.size());
      end
   endtask

   task automatic test_timeout();
      int n, a;
      ev_t e, o;
      apply_reset();
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (timeout_flag === 1'b1) break;
         n++;
      end
      checks++;
      if (n != 54) begin
         failures++;
         $display("FAIL timeout_delay got=%0d exp=54", n);
      end
      checks++;
      if (pll_rst !== 1'b1) begin
         failures++;
         $display("FAIL retry_pulse_start got=%b exp=1", pll_rst);
      end
      n = 1;
      repeat (20) begin
         @(negedge clk);
         if (pll_rst === 1'b1) n++;
         else break;
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL retry_pulse_len got=%0d exp=4", n);
      end
      tick();
      locked = 1'b1;
      a = cyc;
      push_ev(a + 10, 3'b110, 1'b0);
      push_ev(a + 13, 3'b100, 1'b0);
      push_ev(a + 16, 3'b000, 1'b1);
      repeat (25) tick();
      while (exq.size() > 0) begin
         e = exq.pop_front();
         checks++;
         if (obq.size() == 0) begin
            failures++;
            $display("FAIL retry_seq missing cyc=%0d exp=%b",
                     e.cyc, e.rst);
         end else begin
            o = obq.pop_front();
            if (o.cyc !== e.cyc || o.rst !== e.rst ||
                o.rdy !== e.rdy) begin
               failures++;
               $display("FAIL retry_seq got=%0d/%b/%b exp=%0d/%b/%b",
                        o.cyc, o.rst, o.rdy, e.cyc, e.rst, e.rdy);
            end
         end
      end
      checks++;
      if (timeout_flag !== 1'b1) begin
         failures++;
         $display("FAIL tflag_sticky got=%b exp=1", timeout_flag);
      end
   endtask

   task automatic test_glitch();
      int b;
      ev_t e, o;
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      repeat (6) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      b = cyc;
      push_ev(b + 10, 3'b110, 1'b0);
      push_ev(b + 13, 3'b100, 1'b0);
      push_ev(b + 16, 3'b000, 1'b1);
      repeat (25) tick();
      while (exq.size() > 0) begin
         e = exq.pop_front();
         checks++;
         if (obq.size() == 0) begin
            failures++;
            $display("FAIL glitch_seq missing cyc=%0d exp=%b",
                     e.cyc, e.rst);
         end else begin
            o = obq.pop_front();
            if (o.cyc !== e.cyc || o.rst !== e.rst ||
                o.rdy !== e.rdy) begin
               failures++;
               $display("FAIL glitch_seq got=%0d/%b/%b exp=%0d/%b/%b",
                        o.cyc, o.rst, o.rdy, e.cyc, e.rst, e.rdy);
            end
         end
      end
      checks++;
      if (lock_loss_cnt !== 2'd0) begin
         failures++;
         $display("FAIL glitch_cnt got=%0d exp=0", lock_loss_cnt);
      end
   endtask

   task automatic test_loss_run();
      int a, d, n;
      ev_t e, o;
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      a = cyc;
      push_ev(a + 10, 3'b110, 1'b0);
      push_ev(a + 13, 3'b100, 1'b0);
      push_ev(a + 16, 3'b000, 1'b1);
      repeat (25) tick();
      locked = 1'b0;
      d = cyc;
      push_ev(d + 3, 3'b111, 1'b0);
      repeat (10) begin
         @(negedge clk);
         if (pll_rst === 1'b1) break;
      end
      checks++;
      if (pll_rst !== 1'b1 || cyc != d + 3) begin
         failures++;
         $display("FAIL loss_pulse_rise got=%0d/%b exp=%0d/1",
                  cyc, pll_rst, d + 3);
      end
      n = 1;
      repeat (20) begin
         @(negedge clk);
         if (pll_rst === 1'b1) n++;
         else break;
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL loss_pulse_len got=%0d exp=4", n);
      end
      while (exq.size() > 0) begin
         e = exq.pop_front();
         checks++;
         if (obq.size() == 0) begin
            failures++;
            $display("FAIL loss_seq missing cyc=%0d exp=%b",
                     e.cyc, e.rst);
         end else begin
            o = obq.pop_front();
            if (o.cyc !== e.cyc || o.rst !== e.rst ||
                o.rdy !== e.rdy) begin
               failures++;
               $display("FAIL loss_seq got=%0d/%b/%b exp=%0d/%b/%b",
                        o.cyc, o.rst, o.rdy, e.cyc, e.rst, e.rdy);
            end
         end
      end
      checks++;
      if (lock_loss_cnt !== 2'd1) begin
         failures++;
         $display("FAIL loss_cnt got=%0d exp=1", lock_loss_cnt);
      end
   endtask

   task automatic test_saturation();
      int n;
      logic [1:0] exp_cnt;
      apply_reset();
      exp_cnt = 2'd0;
      for (int k = 0; k < 5; k++) begin
         locked = 1'b1;
         n = 0;
         repeat (80) begin
            tick();
            if (ready === 1'b1) break;
            n++;
         end
         locked = 1'b0;
         repeat (6) tick();
         if (exp_cnt != 2'd3) exp_cnt++;
         checks++;
         if (n == 80 || lock_loss_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL sat_cnt[%0d] got=%0d exp=%0d wait=%0d",
                     k, lock_loss_cnt, exp_cnt, n);
         end
      end
   endtask

   task automatic test_force_relock();
      int a, f, g;
      ev_t e, o;
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      a = cyc;
      push_ev(a + 10, 3'b110, 1'b0);
      repeat (11) tick();
      force_relock = 1'b1;
      f = cyc;
      tick();
      force_relock = 1'b0;
      push_ev(f + 1, 3'b111, 1'b0);
      push_ev(f + 13, 3'b110, 1'b0);
      push_ev(f + 16, 3'b100, 1'b0);
      push_ev(f + 19, 3'b000, 1'b1);
      repeat (25) tick();
      checks++;
      if (lock_loss_cnt !== 2'd0) begin
         failures++;
         $display("FAIL force_cnt got=%0d exp=0", lock_loss_cnt);
      end
      locked = 1'b0;
      g = cyc;
      repeat (2) tick();
      force_relock = 1'b1;
      tick();
      force_relock = 1'b0;
      push_ev(g + 3, 3'b111, 1'b0);
      repeat (5) tick();
      while (exq.size() > 0) begin
         e = exq.pop_front();
         checks++;
         if (obq.size() == 0) begin
            failures++;
            $display("FAIL force_seq missing cyc=%0d exp=%b",
                     e.cyc, e.rst);
         end else begin
            o = obq.pop_front();
            if (o.cyc !== e.cyc || o.rst !== e.rst ||
                o.rdy !== e.rdy) begin
               failures++;
               $display("FAIL force_seq got=%0d/%b/%b exp=%0d/%b/%b",
                        o.cyc, o.rst, o.rdy, e.cyc, e.rst, e.rdy);
            end
         end
      end
      checks++;
      if (lock_loss_cnt !== 2'd1) begin
         failures++;
         $display("FAIL force_loss_cnt got=%0d exp=1",
                  lock_loss_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      locked = 1'b0;
      force_relock = 1'b0;
      test_reset();
      test_clean_lock();
      test_timeout();
      test_glitch();
      test_loss_run();
      test_saturation();
      test_force_relock();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
